fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS core. It sits directly upstream of the decode controller.
- Owns the PC register and drives the instruction-memory word address.
- Latches the fetched word into the IF/ID pipeline register that feeds the decoder.
- Applies stall, redirect (branch/jump/jr resolved downstream) and syscall halt/resume.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (low 2 bits must be 0)
IMEM_AW, 10, instruction-memory word-address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_addr  output  IMEM_AW  word address to instruction memory, equals pc[IMEM_AW+1:2], combinational from pc
imem_data  input  32  instruction word, combinational read of imem_addr
stall  input  1  hazard unit: hold PC and IF/ID
redirect  input  1  taken branch / jump / jr resolved downstream
redirect_target  input  32  new PC when redirect=1
halt_req  input  1  syscall halt request from later stage
resume  input  1  restart fetch after halt
pc  output  32  current fetch PC
if_id_instr  output  32  latched instruction to decoder
if_id_pc4  output  32  PC+4 of latched instruction
if_id_valid  output  1  IF/ID holds a real instruction
halted  output  1  1 while in HALT state
fetch_count  output  32  fetched-instruction counter, see Optional Feature

Behaviour:
Reset (rst=1 at edge, overrides everything):
- pc=RESET_PC, if_id_instr=0 (NOP), if_id_pc4=0, if_id_valid=0, state=RUN, halted=0, fetch_count=0.

State machine: RUN, HALT. halted = (state==HALT).

RUN, priority per edge (highest first):
1. halt_req=1:
   - state->HALT.
   - IF/ID flushed (instr=0, pc4=0, valid=0).
   - pc <= redirect ? {redirect_target[31:2],2'b00} : pc, so resume continues at the correct PC.
2. redirect=1:
   - pc <= {redirect_target[31:2],2'b00}.
   - IF/ID flushed (instr=0, pc4=0, valid=0).
   - Redirect overrides stall.
3. stall=1: pc, if_id_instr, if_id_pc4 and if_id_valid all hold.
4. else:
   - if_id_instr <= imem_data, if_id_pc4 <= pc+4, if_id_valid <= 1.
   - pc <= pc+4.

HALT:
- pc and IF/ID hold (IF/ID stays flushed); stall, redirect and halt_req are ignored.
- resume=1 -> RUN at the next edge, with no fetch on that edge.
- First fetch occurs the cycle after return to RUN.
- resume in RUN is ignored.

Latency and arithmetic:
- Fetch-to-decode latency is 1 cycle: word at pc appears on if_id_instr after the next edge.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000; if_id_pc4 wraps identically.
- pc[1:0] is always 2'b00; redirect_target[1:0] is discarded.
- imem_addr truncates pc to IMEM_AW word bits, so a pc beyond memory aliases.
- Reset asserted mid-halt or mid-stall returns to the reset values immediately on that edge.

Optional Feature:
Macro FETCH_CNT_EN.
- Defined: fetch_count increments by 1 on every edge where IF/ID loads with valid=1 (case 4 only). It wraps 32'hFFFF_FFFF->0, is cleared by reset, and does not count flushes, stalls or HALT cycles.
- Undefined: fetch_count is tied to 32'h0 and no counter register is built. The port exists in both builds.

Test Plan:
- Reset release, imem returns word = address*4, no stall: pc 0x0,0x4,0x8; if_id_instr lags pc by one cycle; if_id_pc4 = 0x4,0x8; valid=1 from the second edge.
- stall=1 for 3 cycles at pc=0x8: pc, if_id_instr and if_id_pc4=0x8 are all stable for 3 cycles; progress resumes when stall drops.
- redirect=1 with stall=1, redirect_target=0x0000_0103: next pc=0x0000_0100, if_id_valid=0, if_id_instr=0; the following cycle fetches from word address 0x40.
- halt_req=1 at pc=0x20: halted=1, pc=0x20 and valid=0 held for 5 cycles while redirect pulses are ignored; resume=1 leaves HALT with no fetch that edge; the next edge latches the instruction at 0x20 and pc=0x24.
- RESET_PC=32'hFFFF_FFF8: pc goes 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; if_id_pc4 shows 0x0000_0000 for the 0xFFFF_FFFC word.
- FETCH_CNT_EN defined, 10 clean fetches, 1 redirect, 2 stalls, then halt: fetch_count=10. With the macro undefined, the same stimulus gives fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, stall/redirect/halt control.
// Optional fetched-instruction counter enabled by defining FETCH_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_target,
    input  logic               halt_req,
    input  logic               resume,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic               halted,
    output logic [31:0]        fetch_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_halted;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc;
    logic        w_unused_bits;

    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_redirect_pc = {redirect_target[31:2], 2'b00};
    // Target byte-offset bits are architecturally meaningless and dropped.
    assign w_unused_bits = &{1'b0, redirect_target[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_halted <= 1'b0;
            r_pc     <= {RESET_PC[31:2], 2'b00};
            r_instr  <= 32'h0;
            r_pc4    <= 32'h0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (halt_req) begin
                        // A redirect on the halt edge is kept so resume restarts at the right PC.
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                        r_instr  <= 32'h0;
                        r_pc4    <= 32'h0;
                        r_valid  <= 1'b0;
                        if (redirect) begin
                            r_pc <= w_redirect_pc;
                        end
                    end else if (redirect) begin
                        r_pc    <= w_redirect_pc;
                        r_instr <= 32'h0;
                        r_pc4   <= 32'h0;
                        r_valid <= 1'b0;
                    end else if (!stall) begin
                        r_instr <= imem_data;
                        r_pc4   <= w_pc_plus4;
                        r_valid <= 1'b1;
                        r_pc    <= w_pc_plus4;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_CNT_EN
    logic [31:0] r_fetch_count;
    logic        w_fetch;

    assign w_fetch = (r_state == ST_RUN) && !halt_req && !redirect && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_count <= 32'h0;
        end else if (w_fetch) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    assign fetch_count = 32'h0;
`endif

    assign imem_addr   = r_pc[IMEM_AW+1:2];
    assign pc          = r_pc;
    assign if_id_instr = r_instr;
    assign if_id_pc4   = r_pc4;
    assign if_id_valid = r_valid;
    assign halted      = r_halted;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; a second instance covers PC wrap-around.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic        w_rst;
    logic [9:0]  w_imem_addr;
    logic [31:0] w_imem_data;
    logic [31:0] w_pc;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic        w_halted;
    logic [31:0] w_count;

    int n_checks;
    int n_errors;

    // Memory model: the word at each word address is that address times four.
    assign imem_data   = {20'h0, imem_addr, 2'b00};
    assign w_imem_data = {20'h0, w_imem_addr, 2'b00};

    fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
        .halt_req(halt_req), .resume(resume), .pc(pc), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .halted(halted),
        .fetch_count(fetch_count)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(10)) dut_wrap (
        .clk(clk), .rst(w_rst), .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .stall(1'b0), .redirect(1'b0), .redirect_target(32'h0),
        .halt_req(1'b0), .resume(1'b0), .pc(w_pc), .if_id_instr(w_instr),
        .if_id_pc4(w_pc4), .if_id_valid(w_valid), .halted(w_halted),
        .fetch_count(w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        halt_req = 1'b0; resume = 1'b0;
        step(); step();
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr: got %h expected %h", if_id_instr, 32'h0); end
        n_checks++; if (if_id_pc4 !== 32'h0) begin n_errors++; $display("FAIL reset_pc4: got %h expected %h", if_id_pc4, 32'h0); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        n_checks++; if (fetch_count !== 32'h0) begin n_errors++; $display("FAIL reset_count: got %h expected 0", fetch_count); end
        $display("reset: pc=%h valid=%b halted=%b", pc, if_id_valid, halted);
    endtask

    task automatic test_run();
        rst = 1'b0;
        n_checks++; if (imem_addr !== 10'h0) begin n_errors++; $display("FAIL run_addr0: got %h expected %h", imem_addr, 10'h0); end
        for (int i = 1; i <= 2; i++) begin
            step();
            n_checks++; if (pc !== 32'(i * 4)) begin n_errors++; $display("FAIL run_pc%0d: got %h expected %h", i, pc, 32'(i * 4)); end
            n_checks++; if (if_id_instr !== 32'((i - 1) * 4)) begin n_errors++; $display("FAIL run_instr%0d: got %h expected %h", i, if_id_instr, 32'((i - 1) * 4)); end
            n_checks++; if (if_id_pc4 !== 32'(i * 4)) begin n_errors++; $display("FAIL run_pc4%0d: got %h expected %h", i, if_id_pc4, 32'(i * 4)); end
            n_checks++; if (if_id_valid !== 1'b1) begin n_errors++; $display("FAIL run_valid%0d: got %b expected 1", i, if_id_valid); end
            $display("run: pc=%h instr=%h pc4=%h valid=%b", pc, if_id_instr, if_id_pc4, if_id_valid);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (pc !== 32'h8) begin n_errors++; $display("FAIL stall_pc%0d: got %h expected %h", i, pc, 32'h8); end
            n_checks++; if (if_id_instr !== 32'h4) begin n_errors++; $display("FAIL stall_instr%0d: got %h expected %h", i, if_id_instr, 32'h4); end
            n_checks++; if (if_id_pc4 !== 32'h8) begin n_errors++; $display("FAIL stall_pc4%0d: got %h expected %h", i, if_id_pc4, 32'h8); end
            $display("stall: pc=%h instr=%h pc4=%h", pc, if_id_instr, if_id_pc4);
        end
        stall = 1'b0;
        step();
        n_checks++; if (pc !== 32'hC) begin n_errors++; $display("FAIL stall_exit_pc: got %h expected %h", pc, 32'hC); end
        n_checks++; if (if_id_instr !== 32'h8) begin n_errors++; $display("FAIL stall_exit_instr: got %h expected %h", if_id_instr, 32'h8); end
        $display("stall release: pc=%h instr=%h", pc, if_id_instr);
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0103;
        step();
        stall = 1'b0; redirect = 1'b0;
        n_checks++; if (pc !== 32'h100) begin n_errors++; $display("FAIL redir_pc: got %h expected %h", pc, 32'h100); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL redir_valid: got %b expected 0", if_id_valid); end
        n_checks++; if (if_id_instr !== 32'h0) begin n_errors++; $display("FAIL redir_instr: got %h expected 0", if_id_instr); end
        n_checks++; if (if_id_pc4 !== 32'h0) begin n_errors++; $display("FAIL redir_pc4: got %h expected 0", if_id_pc4); end
        n_checks++; if (imem_addr !== 10'h40) begin n_errors++; $display("FAIL redir_addr: got %h expected %h", imem_addr, 10'h40); end
        $display("redirect: pc=%h valid=%b addr=%h", pc, if_id_valid, imem_addr);
        step();
        n_checks++; if (if_id_instr !== 32'h100) begin n_errors++; $display("FAIL redir_fetch_instr: got %h expected %h", if_id_instr, 32'h100); end
        n_checks++; if (pc !== 32'h104) begin n_errors++; $display("FAIL redir_fetch_pc: got %h expected %h", pc, 32'h104); end
        n_checks++; if (if_id_valid !== 1'b1) begin n_errors++; $display("FAIL redir_fetch_valid: got %b expected 1", if_id_valid); end
        $display("after redirect: pc=%h instr=%h", pc, if_id_instr);
    endtask

    task automatic test_alias();
        redirect = 1'b1; redirect_target = 32'h0000_1004;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_addr !== 10'h001) begin n_errors++; $display("FAIL alias_addr: got %h expected %h", imem_addr, 10'h001); end
        step();
        n_checks++; if (if_id_instr !== 32'h4) begin n_errors++; $display("FAIL alias_instr: got %h expected %h", if_id_instr, 32'h4); end
        n_checks++; if (if_id_pc4 !== 32'h1008) begin n_errors++; $display("FAIL alias_pc4: got %h expected %h", if_id_pc4, 32'h1008); end
        $display("alias: pc=%h instr=%h pc4=%h", pc, if_id_instr, if_id_pc4);
    endtask

    task automatic test_halt();
        redirect = 1'b1; redirect_target = 32'h20;
        step();
        redirect = 1'b0; halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_enter: got %b expected 1", halted); end
        for (int i = 0; i < 5; i++) begin
            redirect = i[0]; redirect_target = 32'h200; stall = ~i[0];
            step();
            n_checks++; if (pc !== 32'h20) begin n_errors++; $display("FAIL halt_pc%0d: got %h expected %h", i, pc, 32'h20); end
            n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL halt_valid%0d: got %b expected 0", i, if_id_valid); end
            n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_hold%0d: got %b expected 1", i, halted); end
            $display("halt: pc=%h valid=%b halted=%b", pc, if_id_valid, halted);
        end
        redirect = 1'b0; stall = 1'b0; resume = 1'b1;
        step();
        resume = 1'b0;
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL resume_halted: got %b expected 0", halted); end
        n_checks++; if (pc !== 32'h20) begin n_errors++; $display("FAIL resume_pc: got %h expected %h", pc, 32'h20); end
        n_checks++; if (if_id_valid !== 1'b0) begin n_errors++; $display("FAIL resume_valid: got %b expected 0", if_id_valid); end
        step();
        n_checks++; if (if_id_instr !== 32'h20) begin n_errors++; $display("FAIL resume_instr: got %h expected %h", if_id_instr, 32'h20); end
        n_checks++; if (pc !== 32'h24) begin n_errors++; $display("FAIL resume_fetch_pc: got %h expected %h", pc, 32'h24); end
        $display("resume: pc=%h instr=%h valid=%b", pc, if_id_instr, if_id_valid);
        // Halt together with a redirect: the redirect PC must be kept for resume.
        halt_req = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0302;
        step();
        halt_req = 1'b0; redirect = 1'b0;
        n_checks++; if (pc !== 32'h300) begin n_errors++; $display("FAIL halt_redir_pc: got %h expected %h", pc, 32'h300); end
        n_checks++; if (halted !== 1'b1) begin n_errors++; $display("FAIL halt_redir_halted: got %b expected 1", halted); end
        $display("halt+redirect: pc=%h halted=%b", pc, halted);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (halted !== 1'b0) begin n_errors++; $display("FAIL halt_reset_halted: got %b expected 0", halted); end
        n_checks++; if (pc !== 32'h0) begin n_errors++; $display("FAIL halt_reset_pc: got %h expected 0", pc); end
        $display("reset in halt: pc=%h halted=%b", pc, halted);
    endtask

    task automatic test_wrap();
        w_rst = 1'b1;
        step();
        n_checks++; if (w_pc !== 32'hFFFF_FFF8) begin n_errors++; $display("FAIL wrap_reset_pc: got %h expected %h", w_pc, 32'hFFFF_FFF8); end
        w_rst = 1'b0;
        step();
        n_checks++; if (w_pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_pc1: got %h expected %h", w_pc, 32'hFFFF_FFFC); end
        n_checks++; if (w_imem_addr !== 10'h3FF) begin n_errors++; $display("FAIL wrap_addr: got %h expected %h", w_imem_addr, 10'h3FF); end
        n_checks++; if (w_instr !== 32'hFF8) begin n_errors++; $display("FAIL wrap_instr1: got %h expected %h", w_instr, 32'hFF8); end
        step();
        n_checks++; if (w_pc !== 32'h0) begin n_errors++; $display("FAIL wrap_pc2: got %h expected 0", w_pc); end
        n_checks++; if (w_instr !== 32'hFFC) begin n_errors++; $display("FAIL wrap_instr2: got %h expected %h", w_instr, 32'hFFC); end
        n_checks++; if (w_pc4 !== 32'h0) begin n_errors++; $display("FAIL wrap_pc4: got %h expected 0", w_pc4); end
        $display("wrap: pc=%h instr=%h pc4=%h", w_pc, w_instr, w_pc4);
    endtask

    task automatic test_fetch_count();
        logic [31:0] exp_count;
`ifdef FETCH_CNT_EN
        exp_count = 32'd10;
`else
        exp_count = 32'd0;
`endif
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        redirect = 1'b1; redirect_target = 32'h80;
        step();
        redirect = 1'b0; stall = 1'b1;
        step(); step();
        stall = 1'b0; halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        n_checks++; if (fetch_count !== exp_count) begin n_errors++; $display("FAIL fetch_count: got %0d expected %0d", fetch_count, exp_count); end
        $display("fetch_count: %0d halted=%b", fetch_count, halted);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        w_rst = 1'b1;
        test_reset();
        test_run();
        test_stall();
        test_redirect();
        test_alias();
        test_halt();
        test_wrap();
        test_fetch_count();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
